// File: rtl/moore_seq.sv
// Moore detector for the serial pattern 1-0-1-0, non-overlapping.
// z is decoded from the state register only, so x never reaches it combinationally.
//
// state | meaning
// S0    | idle, no progress
// S1    | "1" received
// S2    | "10" received
// S3    | "101" received
// S4    | "1010" matched, z=1
module moore_seq (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic z
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state;
   state_t state_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S0;
      end else begin
         state <= state_nx;
      end
   end

   // S4 restarts from scratch so the trailing "10" of a match is not reused
   always_comb begin
      state_nx = S0;
      z        = 1'b0;
      case (state)
         S0: state_nx = x ? S1 : S0;
         S1: state_nx = x ? S1 : S2;
         S2: state_nx = x ? S3 : S0;
         S3: state_nx = x ? S1 : S4;
         S4: begin
            state_nx = x ? S1 : S0;
            z        = 1'b1;
         end
         default: state_nx = S0;
      endcase
   end

endmodule

// File: tb/tb_moore_seq.sv
// Bench for moore_seq: directed pattern cases plus a random stream with
// occasional asynchronous resets, checked against a bit-history reference model.
module tb_moore_seq;

   logic clk;
   logic rst;
   logic x;
   logic z;

   int total = 0;
   int bad   = 0;

   // bits received since the last match or reset
   logic hist[$];
   logic z_exp;

   moore_seq u_dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .z   (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got z=%b, want z=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // reference: a match is the last four bits since the previous match reading 1,0,1,0
   task automatic model_bit(input logic b);
      int n;
      hist.push_back(b);
      n = hist.size();
      z_exp = 1'b0;
      if (n >= 4) begin
         if (hist[n-4] == 1'b1 && hist[n-3] == 1'b0 &&
             hist[n-2] == 1'b1 && hist[n-1] == 1'b0) begin
            z_exp = 1'b1;
            hist.delete();
         end
      end
      if (hist.size() > 4) void'(hist.pop_front());
   endtask

   // called between edges; x settles well before the next rising edge
   task automatic send_bit(input string tag, input logic b);
      x = b;
      @(posedge clk);
      #1;
      model_bit(b);
      chk(tag, z, z_exp);
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      chk({tag, "_async"}, z, 1'b0);
      hist.delete();
      repeat (3) begin
         @(negedge clk);
         x = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         chk({tag, "_hold"}, z, 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // sends v[n-1] first
   task automatic run_bits(input string tag, input logic [15:0] v, input int n);
      logic [15:0] vv;
      vv = v;
      for (int i = n - 1; i >= 0; i--) send_bit(tag, vv[i]);
   endtask

   initial begin
      rst = 1'b0;
      x   = 1'b0;
      #1;
      chk("reset_init", z, 1'b0);
      repeat (4) begin
         @(negedge clk);
         x = ~x;
         @(posedge clk);
         #1;
         chk("reset_hold", z, 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;

      run_bits("basic",      16'b1010,             4);
      send_bit("basic_tail", 1'b0);
      do_reset("r1");
      run_bits("nonovl6",    16'b101010,           6);
      do_reset("r2");
      run_bits("nonovl8",    16'b10101010,         8);
      do_reset("r3");
      run_bits("prefix_a",   16'b11010,            5);
      do_reset("r4");
      run_bits("prefix_b",   16'b1011010,          7);
      do_reset("r5");
      run_bits("prefix_c",   16'b10010,            5);
      do_reset("r6");
      run_bits("stream",     16'b110101011101010, 15);

      // reset while z is high must drop it without a clock edge
      do_reset("r7");
      run_bits("pre_hi",     16'b1010,             4);
      do_reset("r_hi");

      run_bits("mid",        16'b101,              3);
      do_reset("r_mid");
      send_bit("mid_after",  1'b0);
      run_bits("mid_again",  16'b1010,             4);

      // random stream biased toward the pattern, with sporadic resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset("rnd_rst");
         end else if ($urandom_range(0, 3) == 0) begin
            send_bit("rnd", 1'($urandom_range(0, 1)));
         end else begin
            send_bit("rnd", (i % 2 == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
